dtc_vote_decoder: RTL and testbench

//  Consumer end of the dtc classifier output interface. Accepts the 8-bit thermometer-coded class

---
 rtl/dtc_pkg.sv | 27 ++
 rtl/dtc_therm_to_idx.sv | 27 ++
 rtl/dtc_vote_decoder.sv | 155 +++++++++++++++
 tb/tb_dtc_vote_decoder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dtc_pkg.sv
// Shared types and constants for the dtc classifier output path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dtc_pkg;

    localparam int NUM_CLASSES = 9;
    localparam int CLS_W       = 4;
    localparam int CODE_W      = 8;

    // Legal thermometer class words: k ones packed against bit 0 encode class k.
    localparam logic [CODE_W-1:0] CODE_K0 = 8'h00;
    localparam logic [CODE_W-1:0] CODE_K1 = 8'h01;
    localparam logic [CODE_W-1:0] CODE_K2 = 8'h03;
    localparam logic [CODE_W-1:0] CODE_K3 = 8'h07;
    localparam logic [CODE_W-1:0] CODE_K4 = 8'h0F;
    localparam logic [CODE_W-1:0] CODE_K5 = 8'h1F;
    localparam logic [CODE_W-1:0] CODE_K6 = 8'h3F;
    localparam logic [CODE_W-1:0] CODE_K7 = 8'h7F;
    localparam logic [CODE_W-1:0] CODE_K8 = 8'hFF;

    typedef enum logic [1:0] {
        ACC  = 2'd0,
        SCAN = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/dtc_therm_to_idx.sv
// Thermometer class word to class index decoder with legality flag.
// Latency: combinational.
// Backpressure: none, pure function of code.
module dtc_therm_to_idx
    import dtc_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [CLS_W-1:0]  idx,
    output logic              legal
);

    logic [CODE_W-1:0] code_inc;

    // A word is a thermometer code exactly when adding one clears every set bit
    // (0xFF wraps to 0x00, which still satisfies the test).
    assign code_inc = code + 8'd1;
    assign legal    = ((code & code_inc) == '0);

    // Popcount gives the class index for legal words; ignored when illegal.
    always_comb begin
        idx = '0;
        for (int i = 0; i < CODE_W; i++) begin
            idx = idx + CLS_W'(code[i]);
        end
    end

endmodule

// File: rtl/dtc_vote_decoder.sv
// Majority-vote decoder: tallies WINDOW legal class words, then scans for the winning class.
// Latency: last accepted sample in cycle T -> out_valid in cycle T+10 (9-cycle scan).
// Backpressure: in_ready low during SCAN/OUT; result held in OUT until out_ready.
module dtc_vote_decoder
    import dtc_pkg::*;
#(
    parameter  int WINDOW = 8,
    localparam int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CLS_W-1:0]  out_class,
    output logic [CNT_W-1:0]  out_votes,
    output logic [7:0]        err_count,
    output logic              busy
);

    localparam logic [CNT_W-1:0] WIN_C     = CNT_W'(WINDOW);
    localparam logic [CLS_W-1:0] LAST_IDX  = CLS_W'(NUM_CLASSES - 1);

    state_t            state;
    state_t            state_nxt;

    logic [CLS_W-1:0]  dec_idx;
    logic              dec_legal;

    logic [CNT_W-1:0]  vote [NUM_CLASSES];
    logic [CNT_W-1:0]  sample_cnt;
    logic [CNT_W-1:0]  sample_inc;

    logic [CLS_W-1:0]  scan_idx;
    logic [CLS_W-1:0]  best_class;
    logic [CNT_W-1:0]  best_votes;
    logic [CLS_W-1:0]  cand_class;
    logic [CNT_W-1:0]  cand_votes;

    logic              acc_fire;
    logic              legal_fire;
    logic              illegal_fire;
    logic              window_done;
    logic              scan_last;
    logic              out_fire;

    dtc_therm_to_idx u_dec (
        .code  (in_code),
        .idx   (dec_idx),
        .legal (dec_legal)
    );

    assign acc_fire     = in_valid && (state == ACC);
    assign legal_fire   = acc_fire && dec_legal;
    assign illegal_fire = acc_fire && !dec_legal;
    assign sample_inc   = sample_cnt + CNT_W'(1);
    // Only a legal word can close the window; illegal ones never advance sample_cnt.
    assign window_done  = legal_fire && (sample_inc == WIN_C);
    assign scan_last    = (state == SCAN) && (scan_idx == LAST_IDX);
    assign out_fire     = (state == OUT) && out_ready;

    // Strict compare keeps the earlier (lower) index on ties.
    assign cand_class = (vote[scan_idx] > best_votes) ? scan_idx       : best_class;
    assign cand_votes = (vote[scan_idx] > best_votes) ? vote[scan_idx] : best_votes;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and handshake/status outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            ACC: begin
                in_ready = 1'b1;
                if (window_done) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (scan_last) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ACC;
                end
            end
            default: begin
                state_nxt = ACC;
            end
        endcase
    end

    // Per-class vote counters and window sample count; wiped once the result is taken.
    always_ff @(posedge clk) begin
        if (rst || out_fire) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                vote[i] <= '0;
            end
            sample_cnt <= '0;
        end else if (legal_fire) begin
            vote[dec_idx] <= vote[dec_idx] + CNT_W'(1);
            sample_cnt    <= sample_inc;
        end
    end

    // Saturating count of illegal words; survives window boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (illegal_fire && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

    // Scan walker: visits one class per cycle, tracking the running best.
    always_ff @(posedge clk) begin
        if (rst || out_fire) begin
            scan_idx   <= '0;
            best_class <= '0;
            best_votes <= '0;
        end else if (state == SCAN) begin
            scan_idx   <= scan_last ? '0 : scan_idx + CLS_W'(1);
            best_class <= cand_class;
            best_votes <= cand_votes;
        end
    end

    // Result registers: loaded on the final scan step, held until the next result.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_class <= '0;
            out_votes <= '0;
        end else if (scan_last) begin
            out_class <= cand_class;
            out_votes <= cand_votes;
        end
    end

endmodule

// File: tb/tb_dtc_vote_decoder.sv
// Self-checking bench for dtc_vote_decoder: reference model plus directed windows.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low in OUT.
module tb_dtc_vote_decoder;
    import dtc_pkg::*;

    localparam int WINDOW = 8;
    localparam int CNT_W  = $clog2(WINDOW + 1);

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [7:0]       in_code   = 8'h00;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [3:0]       out_class;
    logic [CNT_W-1:0] out_votes;
    logic [7:0]       err_count;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int lat    = 0;

    // Reference model state: tallies, samples in window, scan cycles left, result.
    int m_votes [9];
    int m_samples = 0;
    int m_scan    = 0;
    int m_errs    = 0;
    int m_cls     = 0;
    int m_vts     = 0;
    bit m_have    = 1'b0;

    dtc_vote_decoder #(.WINDOW(WINDOW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_votes (out_votes),
        .err_count (err_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Class of a word by matching against 2^k-1; -1 when it is not a thermometer word.
    function automatic int therm_class(input logic [7:0] c);
        logic [8:0] v;
        for (int k = 0; k <= 8; k++) begin
            v = 9'((1 << k) - 1);
            if (c == v[7:0]) return k;
        end
        return -1;
    endfunction

    // Majority: highest tally, lowest class among equals.
    function automatic int majority();
        int mx = 0;
        for (int k = 0; k < 9; k++) if (m_votes[k] > mx) mx = m_votes[k];
        for (int k = 0; k < 9; k++) if (m_votes[k] == mx) return k;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) m_votes[k] <= 0;
            m_samples <= 0;
            m_scan    <= 0;
            m_errs    <= 0;
            m_have    <= 1'b0;
            m_cls     <= 0;
            m_vts     <= 0;
        end else if (m_have) begin
            if (out_ready) begin
                for (int k = 0; k < 9; k++) m_votes[k] <= 0;
                m_samples <= 0;
                m_have    <= 1'b0;
            end
        end else if (m_scan > 0) begin
            m_scan <= m_scan - 1;
            if (m_scan == 1) begin
                m_have <= 1'b1;
                m_cls  <= majority();
                m_vts  <= m_votes[majority()];
            end
        end else if (in_valid) begin
            if (therm_class(in_code) >= 0) begin
                m_votes[therm_class(in_code)] <= m_votes[therm_class(in_code)] + 1;
                m_samples <= m_samples + 1;
                if (m_samples + 1 == WINDOW) m_scan <= 9;
            end else if (m_errs < 255) begin
                m_errs <= m_errs + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // One clock: edge, then compare every output against the model on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check("in_ready",  in_ready,  32'(!m_have && m_scan == 0));
        check("busy",      busy,      32'(m_have || m_scan != 0));
        check("out_valid", out_valid, 32'(m_have));
        check("out_class", out_class, m_cls);
        check("out_votes", out_votes, m_vts);
        check("err_count", err_count, m_errs);
    endtask

    task automatic send_n(input logic [7:0] code, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_code  = code;
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Counts idle cycles after the last accept until out_valid; the accept
    // cycle itself is one more, so the end-to-end latency is lat+1.
    task automatic wait_out();
        lat = 0;
        while (!out_valid && lat < 30) begin
            tick();
            lat++;
        end
        check("result_timeout", 32'(out_valid), 1);
    endtask

    task automatic take_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready",  in_ready,  1);
        check("rst_busy",      busy,      0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_class", out_class, 0);
        check("rst_out_votes", out_votes, 0);
        check("rst_err_count", err_count, 0);

        // Unanimous class 4, with end-to-end latency.
        send_n(CODE_K4, 8);
        wait_out();
        check("t1_latency", lat + 1, 10);
        check("t1_class", out_class, 4);
        check("t1_votes", out_votes, 8);
        take_out();
        check("t1_ready_after", in_ready, 1);

        // 4:4 tie between classes 3 and 6 resolves to the lower index.
        send_n(CODE_K3, 4);
        send_n(CODE_K6, 4);
        wait_out();
        check("t2_class", out_class, 3);
        check("t2_votes", out_votes, 4);
        take_out();

        // Illegal words are counted but not voted; one lands where the 8th sample would.
        send_n(CODE_K1, 3);
        send_n(8'h05, 1);
        send_n(CODE_K1, 4);
        send_n(8'h80, 1);
        check("t3_no_scan_on_illegal", in_ready, 1);
        send_n(CODE_K1, 1);
        wait_out();
        check("t3_err", err_count, 2);
        check("t3_class", out_class, 1);
        check("t3_votes", out_votes, 8);
        take_out();

        // Extreme classes 0 and 8.
        send_n(CODE_K0, 5);
        send_n(CODE_K8, 3);
        wait_out();
        check("t4a_class", out_class, 0);
        check("t4a_votes", out_votes, 5);
        take_out();
        send_n(CODE_K8, 8);
        wait_out();
        check("t4b_class", out_class, 8);
        check("t4b_votes", out_votes, 8);
        take_out();

        // Result held under backpressure while the source keeps offering words.
        send_n(CODE_K2, 8);
        wait_out();
        in_valid = 1'b1;
        in_code  = CODE_K1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t5_hold_valid", out_valid, 1);
            check("t5_hold_class", out_class, 2);
            check("t5_hold_votes", out_votes, 8);
            check("t5_hold_ready", in_ready,  0);
        end
        in_valid = 1'b0;
        take_out();
        check("t5_ready_after", in_ready, 1);
        send_n(CODE_K1, 8);
        wait_out();
        check("t5_class", out_class, 1);
        check("t5_votes", out_votes, 8);
        take_out();

        // Reset in the 4th scan cycle discards the window.
        send_n(CODE_K2, 8);
        tick();
        tick();
        tick();
        check("t6_in_scan", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_in_ready", in_ready,  1);
        check("t6_busy",     busy,      0);
        check("t6_valid",    out_valid, 0);
        check("t6_class",    out_class, 0);
        check("t6_votes",    out_votes, 0);
        check("t6_err",      err_count, 0);
        send_n(CODE_K5, 8);
        wait_out();
        check("t6_new_class", out_class, 5);
        check("t6_new_votes", out_votes, 8);
        take_out();

        // Error counter saturation.
        send_n(8'h05, 300);
        check("sat_err",  err_count, 255);
        check("sat_busy", busy,      0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
